// File: rtl/unit_branch_rs_pkg.sv
// Shared types for the branch reservation station: tags, CDB bus, jump opcodes,
// entry record and the operand capture rule used at issue and at wake-up.
package unit_branch_rs_pkg;

  localparam int NUM_SRBITS = 6;
  localparam int FU_TAG_W   = NUM_SRBITS - 3;
  localparam logic [FU_TAG_W-1:0] FU_BRANCH_TAG = 3'd2;

  typedef logic [NUM_SRBITS-1:0] tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [31:0] val;
  } tagged_data_t;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [31:0] data;
  } cdb_bus_t;

  localparam logic [3:0] JOP_BEQ  = 4'd0;
  localparam logic [3:0] JOP_BNE  = 4'd1;
  localparam logic [3:0] JOP_BLT  = 4'd4;
  localparam logic [3:0] JOP_BGE  = 4'd5;
  localparam logic [3:0] JOP_BLTU = 4'd6;
  localparam logic [3:0] JOP_BGEU = 4'd7;
  localparam logic [3:0] JOP_JAL  = 4'd8;
  localparam logic [3:0] JOP_JALR = 4'd9;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  typedef struct packed {
    logic [1:0]  state;
    tag_t        q1;
    tag_t        q2;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  op;
  } branch_entry_t;

  // Tag 0 means the value is already present; a matching CDB broadcast resolves it.
  function automatic tagged_data_t operand_capture(input tagged_data_t opnd, input cdb_bus_t cdb);
    tagged_data_t r;
    r = opnd;
    if (opnd.tag != '0 && cdb.valid && cdb.tag == opnd.tag) begin
      r.tag = '0;
      r.val = cdb.data;
    end
    return r;
  endfunction

endpackage

// File: rtl/unit_branch_rs_if.sv
// Issue / flush / CDB bundle of the branch reservation station.
interface unit_branch_rs_if;
  import unit_branch_rs_pkg::*;

  // Issue transfers on a cycle with issue_valid && issue_ready && !flush; the CDB
  // result transfers on cdb_request && cdb_grant and is held stable until then.
  logic         issue_valid;
  logic         issue_ujump;
  logic [3:0]   jump_op;
  tagged_data_t op_a_i;
  tagged_data_t op_b_i;
  logic [31:0]  imm;
  logic [31:0]  pc;
  logic         issue_ready;
  tag_t         issue_tag;
  logic         flush;
  cdb_bus_t     cdb_i;
  logic         cdb_request;
  logic         cdb_grant;
  tagged_data_t cdb_data_o;
  logic [31:0]  cdb_next_pc_o;
  logic         cdb_taken_o;

  modport slave (
    input  issue_valid, issue_ujump, jump_op, op_a_i, op_b_i, imm, pc, flush, cdb_i, cdb_grant,
    output issue_ready, issue_tag, cdb_request, cdb_data_o, cdb_next_pc_o, cdb_taken_o
  );

  modport master (
    output issue_valid, issue_ujump, jump_op, op_a_i, op_b_i, imm, pc, flush, cdb_i, cdb_grant,
    input  issue_ready, issue_tag, cdb_request, cdb_data_o, cdb_next_pc_o, cdb_taken_o
  );

endinterface

// File: rtl/unit_branch_rs_branch_resolve.sv
// Combinational branch/jump resolution: taken decision, next PC and link value.
module branch_resolve
  import unit_branch_rs_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  output logic        taken_o,
  output logic [31:0] next_pc_o,
  output logic [31:0] link_o
);

  logic [31:0] target;

  assign link_o = pc_i + 32'd4;

  always_comb begin
    taken_o = 1'b0;
    target  = pc_i + imm_i;
    case (op_i)
      JOP_BEQ:  taken_o = (rs1_i == rs2_i);
      JOP_BNE:  taken_o = (rs1_i != rs2_i);
      JOP_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      JOP_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      JOP_BLTU: taken_o = (rs1_i <  rs2_i);
      JOP_BGEU: taken_o = (rs1_i >= rs2_i);
      JOP_JAL:  taken_o = 1'b1;
      JOP_JALR: begin
        taken_o = 1'b1;
        target  = (rs1_i + imm_i) & ~32'd1;
      end
      default:  taken_o = 1'b0;
    endcase
    next_pc_o = taken_o ? target : link_o;
  end

endmodule

// File: rtl/unit_branch_rs.sv
// Branch/jump reservation station: tag wake-up from the CDB, oldest-ready
// selection through an age matrix, and a registered CDB result slot.
module unit_branch_rs
  import unit_branch_rs_pkg::*;
#(
  parameter int                  NUM_ENTRIES = 4,
  parameter logic [FU_TAG_W-1:0] FU_TAG      = FU_BRANCH_TAG
) (
  input  logic                        clk,
  input  logic                        rst_n,
  unit_branch_rs_if.slave             bus_if,
  output logic [NUM_ENTRIES-1:0][1:0] dbg_state_o
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  branch_entry_t          ent_q [NUM_ENTRIES];
  branch_entry_t          ent_d [NUM_ENTRIES];
  // age_q[i][j] set: entry i was allocated before entry j.
  logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] age_d [NUM_ENTRIES];

  logic             slot_vld_q;
  logic [IDX_W-1:0] slot_idx_q;
  tagged_data_t     slot_data_q;
  logic [31:0]      slot_npc_q;
  logic             slot_taken_q;

  logic [NUM_ENTRIES-1:0] empty_vec, ready_vec, self_m;
  logic                   alloc, pick_vld, slot_free;
  logic [IDX_W-1:0]       alloc_idx, pick_idx;
  tag_t                   alloc_tag, pick_tag;
  logic                   res_taken;
  logic [31:0]            res_npc, res_link;
  tagged_data_t           cap_a, cap_b, wake_1, wake_2;
  logic                   unused_ujump;

  assign unused_ujump = bus_if.issue_ujump;

  always_comb begin
    empty_vec   = '0;
    ready_vec   = '0;
    dbg_state_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      empty_vec[i]   = (ent_q[i].state == ST_EMPTY);
      ready_vec[i]   = (ent_q[i].state == ST_READY);
      dbg_state_o[i] = ent_q[i].state;
    end
  end

  always_comb begin
    alloc_idx = '0;
    alloc_tag = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (empty_vec[i]) begin
        alloc_idx = IDX_W'(i);
        alloc_tag = {FU_TAG, 3'(i + 1)};
      end
    end
  end

  assign bus_if.issue_ready = |empty_vec;
  assign alloc              = bus_if.issue_valid && bus_if.issue_ready && !bus_if.flush;
  assign bus_if.issue_tag   = alloc ? alloc_tag : '0;

  // An entry wins when it is older than every other READY entry.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_tag = '0;
    self_m   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      self_m    = '0;
      self_m[i] = 1'b1;
      if (ready_vec[i] && (&(age_q[i] | ~ready_vec | self_m))) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
        pick_tag = {FU_TAG, 3'(i + 1)};
      end
    end
  end

  assign slot_free = !slot_vld_q || bus_if.cdb_grant;
  assign cap_a     = operand_capture(bus_if.op_a_i, bus_if.cdb_i);
  assign cap_b     = operand_capture(bus_if.op_b_i, bus_if.cdb_i);

  branch_resolve u_resolve (
    .op_i      (ent_q[pick_idx].op),
    .rs1_i     (ent_q[pick_idx].v1),
    .rs2_i     (ent_q[pick_idx].v2),
    .pc_i      (ent_q[pick_idx].pc),
    .imm_i     (ent_q[pick_idx].imm),
    .taken_o   (res_taken),
    .next_pc_o (res_npc),
    .link_o    (res_link)
  );

  always_comb begin
    ent_d  = ent_q;
    age_d  = age_q;
    wake_1 = '0;
    wake_2 = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ent_q[i].state == ST_WAIT) begin
        wake_1 = operand_capture('{tag: ent_q[i].q1, val: ent_q[i].v1}, bus_if.cdb_i);
        wake_2 = operand_capture('{tag: ent_q[i].q2, val: ent_q[i].v2}, bus_if.cdb_i);
        ent_d[i].q1 = wake_1.tag;
        ent_d[i].v1 = wake_1.val;
        ent_d[i].q2 = wake_2.tag;
        ent_d[i].v2 = wake_2.val;
        if (wake_1.tag == '0 && wake_2.tag == '0) ent_d[i].state = ST_READY;
      end
    end
    if (slot_vld_q && bus_if.cdb_grant) ent_d[slot_idx_q].state = ST_EMPTY;
    if (slot_free && pick_vld)          ent_d[pick_idx].state   = ST_OUT;
    if (alloc) begin
      ent_d[alloc_idx].state = (cap_a.tag == '0 && cap_b.tag == '0) ? ST_READY : ST_WAIT;
      ent_d[alloc_idx].q1    = cap_a.tag;
      ent_d[alloc_idx].v1    = cap_a.val;
      ent_d[alloc_idx].q2    = cap_b.tag;
      ent_d[alloc_idx].v2    = cap_b.val;
      ent_d[alloc_idx].imm   = bus_if.imm;
      ent_d[alloc_idx].pc    = bus_if.pc;
      ent_d[alloc_idx].op    = bus_if.jump_op;
      age_d[alloc_idx]       = '0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (IDX_W'(j) != alloc_idx) age_d[j][alloc_idx] = 1'b1;
      end
    end
    if (bus_if.flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_d[i] = '0;
        age_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= '0;
        age_q[i] <= '0;
      end
      slot_vld_q   <= 1'b0;
      slot_idx_q   <= '0;
      slot_data_q  <= '0;
      slot_npc_q   <= '0;
      slot_taken_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      age_q <= age_d;
      if (bus_if.flush) begin
        slot_vld_q   <= 1'b0;
        slot_idx_q   <= '0;
        slot_data_q  <= '0;
        slot_npc_q   <= '0;
        slot_taken_q <= 1'b0;
      end else if (slot_free) begin
        slot_vld_q <= pick_vld;
        if (pick_vld) begin
          slot_idx_q   <= pick_idx;
          slot_data_q  <= '{tag: pick_tag, val: res_link};
          slot_npc_q   <= res_npc;
          slot_taken_q <= res_taken;
        end
      end
    end
  end

  assign bus_if.cdb_request   = slot_vld_q;
  assign bus_if.cdb_data_o    = slot_data_q;
  assign bus_if.cdb_next_pc_o = slot_npc_q;
  assign bus_if.cdb_taken_o   = slot_taken_q;

endmodule
